bp_fe_pc_gen_nwide: RTL and testbench

Parametrised front-end PC generator for an N-wide fetch bundle: presents one bundle-start PC per cycle to the I-TLB/I-cache and tracks it through two fetch stages, IF1 and IF2. In IF2 it scans per-lane pre-decode and masks off lanes that are unaligned or younger than the first taken control transfer. It overrides the fetch stream on taken jal/call/ret and keeps a circular return address stack of configurable depth. It sits between the backend redirect path and the I-cache, replacing the fixed two-lane generator.

---
 rtl/bp_fe_pc_gen_nwide.sv | 174 +++++++++++++++++
 tb/tb_bp_fe_pc_gen_nwide.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_pc_gen_nwide.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_pc_gen_nwide
// Brief    : N-wide front-end PC generator with two fetch stages, IF2 lane
//            masking, jal/call/ret override and optional circular RAS
//            (built only when BP_FE_PC_GEN_RAS_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module bp_fe_pc_gen_nwide #(
    parameter int                       vaddr_width_p = 39,
    parameter int                       fetch_width_p = 2,
    parameter int                       ras_els_p     = 4,
    parameter logic [vaddr_width_p-1:0] boot_pc_p     = 'h80000000
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    redirect_v_i,
    input  logic [vaddr_width_p-1:0]                redirect_pc_i,
    output logic [vaddr_width_p-1:0]                next_pc_o,
    input  logic                                    next_pc_yumi_i,
    input  logic                                    fetch_v_i,
    input  logic [fetch_width_p-1:0]                fetch_instr_v_i,
    input  logic [fetch_width_p-1:0]                fetch_is_jal_i,
    input  logic [fetch_width_p-1:0]                fetch_is_call_i,
    input  logic [fetch_width_p-1:0]                fetch_is_ret_i,
    input  logic [fetch_width_p*vaddr_width_p-1:0]  fetch_tgt_i,
    output logic                                    fetch_v_o,
    output logic [vaddr_width_p-1:0]                fetch_pc_o,
    output logic [fetch_width_p-1:0]                fetch_lane_mask_o,
    output logic                                    ovr_o
);

    localparam int c_lg_fw  = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 0;
    localparam int c_lane_w = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;
    localparam logic [vaddr_width_p-1:0] c_align_mask =
        vaddr_width_p'((64'd1 << (2 + c_lg_fw)) - 64'd1);
    localparam logic [vaddr_width_p-1:0] c_bundle_bytes = vaddr_width_p'(4 * fetch_width_p);

    logic [vaddr_width_p-1:0] r_pc_req;
    logic [vaddr_width_p-1:0] r_if1_pc;
    logic [vaddr_width_p-1:0] r_if2_pc;
    logic                     r_if1_v;
    logic                     r_if2_v;

    logic                     w_act;
    logic [c_lane_w-1:0]      w_if2_off;
    logic [vaddr_width_p-1:0] w_if2_base;
    logic [vaddr_width_p-1:0] w_seq_pc;
    logic [fetch_width_p-1:0] w_mask;
    logic                     w_lane_elig;
    logic                     w_lane_take;
    logic                     w_found;
    logic                     w_t_jal;
    logic                     w_t_call;
    logic                     w_t_ret;
    logic [vaddr_width_p-1:0] w_t_tgt;
    logic [vaddr_width_p-1:0] w_t_ret_addr;
    logic [vaddr_width_p-1:0] w_ovr_tgt;
    logic                     w_ras_nonempty;
    logic [vaddr_width_p-1:0] w_ras_top;

    assign w_if2_off  = (fetch_width_p > 1) ? r_if2_pc[2 +: c_lane_w] : '0;
    assign w_if2_base = r_if2_pc & ~c_align_mask;
    assign w_act      = r_if2_v & fetch_v_i & ~redirect_v_i;

    // Single lowest-first scan: lanes are masked in until the first taken one
    always_comb begin
        w_mask       = '0;
        w_lane_elig  = 1'b0;
        w_lane_take  = 1'b0;
        w_found      = 1'b0;
        w_t_jal      = 1'b0;
        w_t_call     = 1'b0;
        w_t_ret      = 1'b0;
        w_t_tgt      = '0;
        w_t_ret_addr = '0;
        for (int k = 0; k < fetch_width_p; k++) begin
            w_lane_elig = fetch_instr_v_i[k] && (c_lane_w'(k) >= w_if2_off);
            w_lane_take = w_lane_elig &&
                          (fetch_is_jal_i[k] || (fetch_is_ret_i[k] && w_ras_nonempty));
            if (w_lane_elig && !w_found) begin
                w_mask[k] = 1'b1;
            end
            if (w_lane_take && !w_found) begin
                w_found      = 1'b1;
                w_t_jal      = fetch_is_jal_i[k];
                w_t_call     = fetch_is_call_i[k];
                w_t_ret      = fetch_is_ret_i[k];
                w_t_tgt      = fetch_tgt_i[k*vaddr_width_p +: vaddr_width_p];
                w_t_ret_addr = w_if2_base + vaddr_width_p'(4 * k + 4);
            end
        end
    end

    assign ovr_o             = w_act & w_found;
    assign w_ovr_tgt         = w_t_jal ? w_t_tgt : w_ras_top;
    assign next_pc_o         = redirect_v_i ? redirect_pc_i :
                               ovr_o        ? w_ovr_tgt     : r_pc_req;
    assign w_seq_pc          = (next_pc_o & ~c_align_mask) + c_bundle_bytes;
    assign fetch_v_o         = w_act;
    assign fetch_pc_o        = r_if2_pc;
    assign fetch_lane_mask_o = w_act ? w_mask : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pc_req <= boot_pc_p;
            r_if1_v  <= 1'b0;
            r_if2_v  <= 1'b0;
        end else begin
            if (next_pc_yumi_i) begin
                r_pc_req <= w_seq_pc;
                r_if1_v  <= 1'b1;
            end else begin
                r_pc_req <= next_pc_o;
                r_if1_v  <= 1'b0;
            end
            // The IF1 bundle is wrong-path whenever the stream is steered this cycle
            r_if2_v <= r_if1_v & ~redirect_v_i & ~ovr_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (next_pc_yumi_i) begin
            r_if1_pc <= next_pc_o;
        end
        r_if2_pc <= r_if1_pc;
    end

`ifdef BP_FE_PC_GEN_RAS_EN
    localparam int c_ras_ptr_w = $clog2(ras_els_p);
    localparam logic [c_ras_ptr_w:0] c_ras_full = (c_ras_ptr_w+1)'(ras_els_p);

    logic [vaddr_width_p-1:0] r_ras_mem [ras_els_p];
    logic [c_ras_ptr_w-1:0]   r_ras_ptr;
    logic [c_ras_ptr_w:0]     r_ras_cnt;
    logic                     w_ras_push;
    logic                     w_ras_pop;

    assign w_ras_nonempty = (r_ras_cnt != '0);
    assign w_ras_top      = r_ras_mem[r_ras_ptr];
    assign w_ras_push     = ovr_o & w_t_call;
    assign w_ras_pop      = ovr_o & w_t_ret & ~w_t_call & w_ras_nonempty;

    // Pointer wraps, so a push on a full stack overwrites the oldest entry
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_ras_push) begin
            r_ras_ptr <= r_ras_ptr + 1'b1;
            if (r_ras_cnt != c_ras_full) begin
                r_ras_cnt <= r_ras_cnt + 1'b1;
            end
        end else if (w_ras_pop) begin
            r_ras_ptr <= r_ras_ptr - 1'b1;
            r_ras_cnt <= r_ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && w_ras_push) begin
            r_ras_mem[r_ras_ptr + 1'b1] <= w_t_ret_addr;
        end
    end
`else
    logic w_unused_ras;

    assign w_ras_nonempty = 1'b0;
    assign w_ras_top      = '0;
    assign w_unused_ras   = ^{w_t_call, w_t_ret, w_t_ret_addr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_pc_gen_nwide.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_fe_pc_gen_nwide
// Brief    : Directed bench for bp_fe_pc_gen_nwide with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_fe_pc_gen_nwide;

    localparam int W   = 39;
    localparam int N   = 2;
    localparam int RAS = 4;
    localparam logic [W-1:0] BOOT = 39'h80000000;
`ifdef BP_FE_PC_GEN_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           redirect_v_i;
    logic [W-1:0]   redirect_pc_i;
    logic [W-1:0]   next_pc_o;
    logic           next_pc_yumi_i;
    logic           fetch_v_i;
    logic [N-1:0]   fetch_instr_v_i;
    logic [N-1:0]   fetch_is_jal_i;
    logic [N-1:0]   fetch_is_call_i;
    logic [N-1:0]   fetch_is_ret_i;
    logic [N*W-1:0] fetch_tgt_i;
    logic           fetch_v_o;
    logic [W-1:0]   fetch_pc_o;
    logic [N-1:0]   fetch_lane_mask_o;
    logic           ovr_o;

    bp_fe_pc_gen_nwide #(
        .vaddr_width_p (W),
        .fetch_width_p (N),
        .ras_els_p     (RAS),
        .boot_pc_p     (BOOT)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .redirect_v_i      (redirect_v_i),
        .redirect_pc_i     (redirect_pc_i),
        .next_pc_o         (next_pc_o),
        .next_pc_yumi_i    (next_pc_yumi_i),
        .fetch_v_i         (fetch_v_i),
        .fetch_instr_v_i   (fetch_instr_v_i),
        .fetch_is_jal_i    (fetch_is_jal_i),
        .fetch_is_call_i   (fetch_is_call_i),
        .fetch_is_ret_i    (fetch_is_ret_i),
        .fetch_tgt_i       (fetch_tgt_i),
        .fetch_v_o         (fetch_v_o),
        .fetch_pc_o        (fetch_pc_o),
        .fetch_lane_mask_o (fetch_lane_mask_o),
        .ovr_o             (ovr_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model state: bundle pipeline and a return-address list (newest at back)
    bit           m_known = 1'b0;
    logic [W-1:0] m_pc_req, m_if1_pc, m_if2_pc;
    bit           m_if1_v, m_if2_v;
    logic [W-1:0] m_ras [$];

    logic [W-1:0] e_next, e_push_addr;
    logic [N-1:0] e_mask;
    bit           e_ovr, e_fv, e_push, e_pop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        int           off;
        int           t;
        logic [W-1:0] base;
        logic [W-1:0] tgt;
        off  = int'((m_if2_pc / W'(4)) % W'(N));
        base = m_if2_pc - (m_if2_pc % W'(4 * N));
        t    = N;
        for (int k = 0; k < N; k++) begin
            if (t == N && k >= off && fetch_instr_v_i[k] &&
                (fetch_is_jal_i[k] || (RAS_EN && fetch_is_ret_i[k] && m_ras.size() > 0)))
                t = k;
        end
        e_fv   = m_if2_v && fetch_v_i && !redirect_v_i;
        e_ovr  = e_fv && (t < N);
        e_mask = '0;
        for (int k = 0; k < N; k++)
            if (k >= off && k <= t && fetch_instr_v_i[k]) e_mask[k] = 1'b1;
        tgt         = '0;
        e_push      = 1'b0;
        e_pop       = 1'b0;
        e_push_addr = '0;
        if (t < N) begin
            if (fetch_is_jal_i[t]) tgt = fetch_tgt_i[t*W +: W];
            else                   tgt = m_ras[$];
            e_push      = e_ovr && RAS_EN && fetch_is_call_i[t];
            e_pop       = e_ovr && RAS_EN && fetch_is_ret_i[t] && !fetch_is_call_i[t] && m_ras.size() > 0;
            e_push_addr = base + W'(4 * t + 4);
        end
        e_next = redirect_v_i ? redirect_pc_i : (e_ovr ? tgt : m_pc_req);
    endtask

    task automatic model_update();
        logic [W-1:0] old_if1_pc;
        bit           old_if1_v;
        if (reset_i) begin
            m_pc_req = BOOT;
            m_if1_v  = 1'b0;
            m_if2_v  = 1'b0;
            m_ras.delete();
            m_known  = 1'b1;
        end else begin
            old_if1_pc = m_if1_pc;
            old_if1_v  = m_if1_v;
            if (next_pc_yumi_i) begin
                m_if1_pc = e_next;
                m_if1_v  = 1'b1;
                m_pc_req = e_next - (e_next % W'(4 * N)) + W'(4 * N);
            end else begin
                m_pc_req = e_next;
                m_if1_v  = 1'b0;
            end
            m_if2_v  = old_if1_v && !redirect_v_i && !e_ovr;
            m_if2_pc = old_if1_pc;
            if (e_push) begin
                m_ras.push_back(e_push_addr);
                if (m_ras.size() > RAS) void'(m_ras.pop_front());
            end else if (e_pop) begin
                void'(m_ras.pop_back());
            end
        end
    endtask

    // Per-cycle comparison against the model
    task automatic settle();
        #1;
        if (m_known) begin
            model_eval();
            chk("next_pc", 64'(next_pc_o), 64'(e_next));
            chk("ovr", 64'(ovr_o), 64'(e_ovr));
            chk("fetch_v", 64'(fetch_v_o), 64'(e_fv));
            if (e_fv) begin
                chk("fetch_pc", 64'(fetch_pc_o), 64'(m_if2_pc));
                chk("lane_mask", 64'(fetch_lane_mask_o), 64'(e_mask));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic idle();
        redirect_v_i    = 1'b0;
        redirect_pc_i   = '0;
        next_pc_yumi_i  = 1'b1;
        fetch_v_i       = 1'b1;
        fetch_instr_v_i = '1;
        fetch_is_jal_i  = '0;
        fetch_is_call_i = '0;
        fetch_is_ret_i  = '0;
        fetch_tgt_i     = '0;
    endtask

    // Redirect to pc, then leave the bench at the cycle where that bundle is in IF2
    task automatic goto_if2(input logic [W-1:0] pc);
        idle();
        redirect_v_i  = 1'b1;
        redirect_pc_i = pc;
        cycle();
        idle();
        cycle();
    endtask

    logic [N-1:0] pat_v   [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
    logic [N-1:0] pat_jal [4] = '{2'b10, 2'b10, 2'b01, 2'b10};

    initial begin
        idle();
        reset_i        = 1'b1;
        next_pc_yumi_i = 1'b0;
        cycle();
        cycle();

        // Reset state and sequential stream
        reset_i        = 1'b0;
        next_pc_yumi_i = 1'b1;
        settle();
        chk("rst_next_pc", 64'(next_pc_o), 64'h80000000);
        chk("rst_ovr", 64'(ovr_o), 64'h0);
        chk("rst_fetch_v", 64'(fetch_v_o), 64'h0);
        chk("rst_mask", 64'(fetch_lane_mask_o), 64'h0);
        advance();
        settle();
        chk("seq_pc1", 64'(next_pc_o), 64'h80000008);
        advance();
        settle();
        chk("seq_pc2", 64'(next_pc_o), 64'h80000010);
        chk("seq_fv2", 64'(fetch_v_o), 64'h1);
        chk("seq_fpc2", 64'(fetch_pc_o), 64'h80000000);
        chk("seq_mask2", 64'(fetch_lane_mask_o), 64'h3);
        advance();
        repeat (3) cycle();

        // Redirect into an unaligned PC
        redirect_v_i  = 1'b1;
        redirect_pc_i = 39'h80000104;
        settle();
        chk("redir_next", 64'(next_pc_o), 64'h80000104);
        chk("redir_fv", 64'(fetch_v_o), 64'h0);
        advance();
        idle();
        settle();
        chk("redir_seq", 64'(next_pc_o), 64'h80000108);
        chk("redir_kill", 64'(fetch_v_o), 64'h0);
        advance();
        settle();
        chk("redir_fpc", 64'(fetch_pc_o), 64'h80000104);
        chk("redir_mask", 64'(fetch_lane_mask_o), 64'h2);
        advance();

        // Call at lane 0, then ret at lane 1 of the target bundle
        goto_if2(39'h80000200);
        fetch_is_jal_i  = 2'b01;
        fetch_is_call_i = 2'b01;
        fetch_tgt_i     = {39'h80005555, 39'h80001000};
        settle();
        chk("call_ovr", 64'(ovr_o), 64'h1);
        chk("call_next", 64'(next_pc_o), 64'h80001000);
        chk("call_mask", 64'(fetch_lane_mask_o), 64'h1);
        advance();
        idle();
        settle();
        chk("call_bubble", 64'(fetch_v_o), 64'h0);
        advance();
        fetch_is_ret_i = 2'b10;
        settle();
        chk("ret_fpc", 64'(fetch_pc_o), 64'h80001000);
        chk("ret_mask", 64'(fetch_lane_mask_o), 64'h3);
        if (RAS_EN) begin
            chk("ret_ovr", 64'(ovr_o), 64'h1);
            chk("ret_next", 64'(next_pc_o), 64'h80000204);
        end else begin
            chk("ret_ovr", 64'(ovr_o), 64'h0);
            chk("ret_next", 64'(next_pc_o), 64'h80001010);
        end
        advance();

        // Five nested calls into a four-entry stack, then five rets
        for (int i = 0; i < 5; i++) begin
            goto_if2(39'h80000300 + W'(i * 'h100));
            fetch_is_jal_i  = 2'b01;
            fetch_is_call_i = 2'b01;
            fetch_tgt_i     = {39'h80005555, 39'h80009000};
            settle();
            chk("nest_call_ovr", 64'(ovr_o), 64'h1);
            advance();
        end
        for (int j = 0; j < 5; j++) begin
            goto_if2(39'h80004000 + W'(j * 'h100));
            fetch_is_ret_i = 2'b01;
            settle();
            if (RAS_EN && j < 4) begin
                chk("nest_ret_ovr", 64'(ovr_o), 64'h1);
                chk("nest_ret_next", 64'(next_pc_o), 64'(39'h80000304 + W'((4 - j) * 'h100)));
            end else begin
                chk("nest_ret_ovr", 64'(ovr_o), 64'h0);
                chk("nest_ret_mask", 64'(fetch_lane_mask_o), 64'h3);
            end
            advance();
        end

        // Redirect and taken call together: redirect wins, no push
        goto_if2(39'h80000500);
        fetch_is_jal_i  = 2'b10;
        fetch_is_call_i = 2'b10;
        fetch_tgt_i     = {39'h80002000, 39'h80005555};
        redirect_v_i    = 1'b1;
        redirect_pc_i   = 39'h80000600;
        settle();
        chk("rvo_next", 64'(next_pc_o), 64'h80000600);
        chk("rvo_ovr", 64'(ovr_o), 64'h0);
        chk("rvo_fv", 64'(fetch_v_o), 64'h0);
        advance();
        goto_if2(39'h80000700);
        fetch_is_ret_i = 2'b01;
        settle();
        chk("rvo_ras_empty", 64'(ovr_o), 64'h0);
        advance();

        // Override with yumi low, held for three more cycles
        goto_if2(39'h80000800);
        fetch_is_jal_i = 2'b01;
        fetch_tgt_i    = {39'h80005555, 39'h80003000};
        next_pc_yumi_i = 1'b0;
        settle();
        chk("hold_ovr", 64'(ovr_o), 64'h1);
        chk("hold_next0", 64'(next_pc_o), 64'h80003000);
        advance();
        idle();
        next_pc_yumi_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_next", 64'(next_pc_o), 64'h80003000);
            advance();
        end
        next_pc_yumi_i = 1'b1;
        cycle();
        settle();
        chk("hold_release", 64'(next_pc_o), 64'h80003008);
        advance();

        // Mixed lane validity and jal positions from aligned bundles
        for (int i = 0; i < 4; i++) begin
            goto_if2(39'h80000a00 + W'(i * 'h40));
            fetch_instr_v_i = pat_v[i];
            fetch_is_jal_i  = pat_jal[i];
            fetch_tgt_i     = {39'h80006000 + W'(i * 8), 39'h80007000 + W'(i * 8)};
            cycle();
        end
        idle();
        repeat (3) cycle();

        // Reset mid-stream discards in-flight bundles
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        settle();
        chk("mrst_next", 64'(next_pc_o), 64'h80000000);
        chk("mrst_fv0", 64'(fetch_v_o), 64'h0);
        advance();
        settle();
        chk("mrst_fv1", 64'(fetch_v_o), 64'h0);
        advance();
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
